// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
//   Master-side SPI transfer controller. It generates SCLK at the programmed
//   baud rate, the slave select, the shifter load/capture pulses and the four
//   per-edge strobes the downstream shifter uses to shift and sample. Each
//   accepted start runs one byte (EDGES SCLK edges).
//
//   Optional build macro: SPI_WAIT_FREEZE_EN
//     defined   : spiswai_i & wait_i freezes an ACTIVE transfer in place
//     undefined : spiswai_i and wait_i have no effect
//
// Ports
//   PCLK, PRESET_n         clock, asynchronous active-low reset
//   mstr_i, spe_i          master mode / SPI enable (either low aborts)
//   cpol_i, cpha_i         clock polarity / phase
//   sppr_i, spr_i          baud pre-select / select
//   start_i                one-cycle transfer request
//   spiswai_i, wait_i      stop-in-wait enable / CPU wait mode
//   ss_o                   slave select, active low
//   sclk_o                 serial clock
//   send_data_o            shifter load pulse (cycle the start is accepted)
//   receive_data_o         received-byte capture pulse (DONE cycle)
//   tip_o                  transfer in progress
//   mosi_send_sclk_o       falling SCLK edge pending -> shift
//   miso_receive_sclk_o    falling SCLK edge now     -> sample
//   mosi_send_sclk0_o      rising SCLK edge pending  -> shift
//   miso_receive_sclk0_o   rising SCLK edge now      -> sample
//   baud_div_o             current baud divisor
// ---------------------------------------------------------------------------
module spi_xfer_ctrl #(
  parameter int DIV_W = 12,
  parameter int EDGES = 16
) (
  input  logic             PCLK,
  input  logic             PRESET_n,
  input  logic             mstr_i,
  input  logic             spe_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [2:0]       sppr_i,
  input  logic [2:0]       spr_i,
  input  logic             start_i,
  input  logic             spiswai_i,
  input  logic             wait_i,
  output logic             ss_o,
  output logic             sclk_o,
  output logic             send_data_o,
  output logic             receive_data_o,
  output logic             tip_o,
  output logic             mosi_send_sclk_o,
  output logic             miso_receive_sclk_o,
  output logic             mosi_send_sclk0_o,
  output logic             miso_receive_sclk0_o,
  output logic [DIV_W-1:0] baud_div_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int EW = $clog2(EDGES + 1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             ss_q, ss_d;
  logic             tip_q, tip_d;
  logic             rx_q, rx_d;
  logic             cpol_q, cpol_d;
  logic [2:0]       sppr_q, sppr_d;
  logic [2:0]       spr_q, spr_d;

  logic             freeze_s;
  logic             run_ok_s;
  logic             send_data_s;
  logic [DIV_W-1:0] pre_s;
  logic [DIV_W-1:0] baud_div_s;
  logic [DIV_W-1:0] hp_s;
  logic [DIV_W-1:0] tc_s;
  logic [DIV_W-1:0] p_cnt_s;
  logic             at_tc_s;
  logic             at_p_s;
  logic             strobe_en_s;
  logic             unused_s;

  // Phase selection lives in the shifter: the four strobes below cover both
  // edges, so cpha does not change anything in this block.
`ifdef SPI_WAIT_FREEZE_EN
  assign freeze_s = spiswai_i & wait_i;
  assign unused_s = cpha_i;
`else
  assign freeze_s = 1'b0;
  assign unused_s = cpha_i ^ spiswai_i ^ wait_i;
`endif

  assign run_ok_s = mstr_i & spe_i;

  // Divisor = (sppr+1) << (spr+1); half period = (sppr+1) << spr.
  assign pre_s      = DIV_W'(sppr_q) + {{(DIV_W-1){1'b0}}, 1'b1};
  assign baud_div_s = pre_s << ({1'b0, spr_q} + 4'd1);
  assign hp_s       = pre_s << spr_q;
  assign tc_s       = hp_s - {{(DIV_W-1){1'b0}}, 1'b1};
  // With a 2-cycle divisor there is no earlier slot, so "pending" and "now"
  // coincide on the terminal count.
  assign p_cnt_s    = (tc_s == {DIV_W{1'b0}}) ? tc_s
                                              : tc_s - {{(DIV_W-1){1'b0}}, 1'b1};
  assign at_tc_s    = (cnt_q == tc_s);
  assign at_p_s     = (cnt_q == p_cnt_s);

  // Next-state, counter, SCLK and shadow-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    cpol_d      = cpol_q;
    sppr_d      = sppr_q;
    spr_d       = spr_q;
    send_data_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Shadows follow the inputs while idle, which also captures them on
        // the accepting start.
        cpol_d = cpol_i;
        sppr_d = sppr_i;
        spr_d  = spr_i;
        sclk_d = cpol_i;
        cnt_d  = {DIV_W{1'b0}};
        edge_d = {EW{1'b0}};
        if (start_i && run_ok_s) begin
          send_data_s = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!run_ok_s) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!run_ok_s) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
          cnt_d   = {DIV_W{1'b0}};
          edge_d  = {EW{1'b0}};
        end else if (freeze_s) begin
          state_d = ST_ACTIVE;
        end else if (at_tc_s) begin
          sclk_d = ~sclk_q;
          cnt_d  = {DIV_W{1'b0}};
          edge_d = edge_q + {{(EW-1){1'b0}}, 1'b1};
          if (edge_q == EW'(EDGES - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = cpol_i;
        cnt_d   = {DIV_W{1'b0}};
        edge_d  = {EW{1'b0}};
      end
    endcase
  end

  // Slave select and busy flag are low/high for LOAD through DONE; the
  // capture pulse is high for the DONE cycle.
  always_comb begin
    ss_d  = (state_d == ST_IDLE);
    tip_d = (state_d != ST_IDLE);
    rx_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {DIV_W{1'b0}};
      edge_q  <= {EW{1'b0}};
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      tip_q   <= 1'b0;
      rx_q    <= 1'b0;
      cpol_q  <= 1'b0;
      sppr_q  <= 3'd0;
      spr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      tip_q   <= tip_d;
      rx_q    <= rx_d;
      cpol_q  <= cpol_d;
      sppr_q  <= sppr_d;
      spr_q   <= spr_d;
    end
  end

  assign strobe_en_s          = (state_q == ST_ACTIVE) & ~freeze_s;
  assign mosi_send_sclk_o     = strobe_en_s & at_p_s  &  sclk_q;
  assign miso_receive_sclk_o  = strobe_en_s & at_tc_s &  sclk_q;
  assign mosi_send_sclk0_o    = strobe_en_s & at_p_s  & ~sclk_q;
  assign miso_receive_sclk0_o = strobe_en_s & at_tc_s & ~sclk_q;

  assign send_data_o    = send_data_s;
  assign receive_data_o = rx_q;
  assign ss_o           = ss_q;
  assign sclk_o         = sclk_q;
  assign tip_o          = tip_q;
  assign baud_div_o     = baud_div_s;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET_n = 1'b0;
  logic        mstr_i = 1'b0;
  logic        spe_i = 1'b0;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [2:0]  sppr_i = 3'd0;
  logic [2:0]  spr_i = 3'd0;
  logic        start_i = 1'b0;
  logic        spiswai_i = 1'b0;
  logic        wait_i = 1'b0;
  logic        ss_o, sclk_o, send_data_o, receive_data_o, tip_o;
  logic        mosi_send_sclk_o, miso_receive_sclk_o;
  logic        mosi_send_sclk0_o, miso_receive_sclk0_o;
  logic [11:0] baud_div_o;

  int checks = 0;
  int errors = 0;

  // results of the last run_xfer
  int r_ss_low, r_ms, r_mr, r_ms0, r_mr0, r_rx, r_tog, r_send, r_pair, r_frz_bad;
  bit r_send0, r_div_changed, r_timeout;
  logic r_ss_end, r_sclk_end, r_tip_end;

  spi_xfer_ctrl #(.DIV_W(12), .EDGES(16)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .mstr_i(mstr_i), .spe_i(spe_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .sppr_i(sppr_i), .spr_i(spr_i),
    .start_i(start_i), .spiswai_i(spiswai_i), .wait_i(wait_i),
    .ss_o(ss_o), .sclk_o(sclk_o), .send_data_o(send_data_o),
    .receive_data_o(receive_data_o), .tip_o(tip_o),
    .mosi_send_sclk_o(mosi_send_sclk_o), .miso_receive_sclk_o(miso_receive_sclk_o),
    .mosi_send_sclk0_o(mosi_send_sclk0_o), .miso_receive_sclk0_o(miso_receive_sclk0_o),
    .baud_div_o(baud_div_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic configure(input logic cpol, input logic [2:0] sppr, input logic [2:0] spr);
    cpol_i = cpol;
    sppr_i = sppr;
    spr_i  = spr;
    tick(2);
  endtask

  // Pulse start and observe one transfer until ss_o returns high.
  // mode 0: plain, 1: drop spe_i after 5 SCLK toggles,
  // 2: change cpol/sppr and pulse start mid-transfer, 3: wait/spiswai for 10 cycles at toggle 7
  task automatic run_xfer(input int mode, input int budget);
    logic prev_sclk, frz_sclk;
    logic [11:0] div0;
    bit prev_ms, prev_frozen, cur_frozen, frz_done, abort_done;
    int frz_left;
    r_ss_low = 0; r_ms = 0; r_mr = 0; r_ms0 = 0; r_mr0 = 0; r_rx = 0; r_tog = 0;
    r_send = 0; r_pair = 0; r_frz_bad = 0; r_div_changed = 1'b0; r_timeout = 1'b1;
    prev_ms = 1'b0; prev_frozen = 1'b0; frz_done = 1'b0; abort_done = 1'b0; frz_left = 0;
    frz_sclk = 1'b0;
    start_i = 1'b1;
    #1;
    r_send0 = send_data_o;
    div0 = baud_div_o;
    prev_sclk = sclk_o;
    for (int c = 0; c < budget; c++) begin
      @(posedge PCLK);
      #1;
      start_i = 1'b0;
      if (sclk_o !== prev_sclk) r_tog++;
      prev_sclk = sclk_o;
      if (prev_frozen && (sclk_o !== frz_sclk)) r_frz_bad++;
      r_ss_end = ss_o; r_sclk_end = sclk_o; r_tip_end = tip_o;
      if (ss_o === 1'b1 && r_ss_low > 0) begin
        r_timeout = 1'b0;
        break;
      end
      if (ss_o === 1'b0) r_ss_low++;
      if (ss_o === 1'b0 && baud_div_o !== div0) r_div_changed = 1'b1;
      if (mode == 1 && !abort_done && r_tog == 5) begin
        spe_i = 1'b0;
        abort_done = 1'b1;
      end
      if (mode == 2 && c == 5) begin
        cpol_i = 1'b1;
        sppr_i = 3'd3;
        start_i = 1'b1;
      end
      if (mode == 3) begin
        if (frz_left > 0) begin
          frz_left--;
          if (frz_left == 0) begin
            spiswai_i = 1'b0;
            wait_i = 1'b0;
          end
        end else if (!frz_done && r_tog == 7) begin
          spiswai_i = 1'b1;
          wait_i = 1'b1;
          frz_left = 10;
          frz_done = 1'b1;
          frz_sclk = sclk_o;
        end
      end
      cur_frozen = spiswai_i && wait_i;
      #1;
      if (send_data_o === 1'b1) r_send++;
      if (receive_data_o === 1'b1) r_rx++;
      if (mosi_send_sclk_o === 1'b1) r_ms++;
      if (miso_receive_sclk_o === 1'b1) r_mr++;
      if (mosi_send_sclk0_o === 1'b1) r_ms0++;
      if (miso_receive_sclk0_o === 1'b1) r_mr0++;
      if (prev_ms && miso_receive_sclk_o === 1'b1) r_pair++;
      prev_ms = (mosi_send_sclk_o === 1'b1);
      if (cur_frozen && (mosi_send_sclk_o | miso_receive_sclk_o |
                         mosi_send_sclk0_o | miso_receive_sclk0_o) !== 1'b0) r_frz_bad++;
      prev_frozen = cur_frozen;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    PRESET_n = 1'b0;
    tick(3);
    checks++; if (ss_o !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b want 1", ss_o); end
    checks++; if (sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk_o); end
    checks++; if (tip_o !== 1'b0) begin errors++; $display("FAIL reset_tip: got %b want 0", tip_o); end
    checks++; if (baud_div_o !== 12'd2) begin errors++; $display("FAIL reset_div: got %0d want 2", baud_div_o); end
    checks++;
    if ({send_data_o, receive_data_o, mosi_send_sclk_o, miso_receive_sclk_o,
         mosi_send_sclk0_o, miso_receive_sclk0_o} !== 6'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 000000",
        {send_data_o, receive_data_o, mosi_send_sclk_o, miso_receive_sclk_o,
         mosi_send_sclk0_o, miso_receive_sclk0_o});
    end
    #3 PRESET_n = 1'b1;
    mstr_i = 1'b1;
    spe_i = 1'b1;
    tick(2);
    checks++; if (ss_o !== 1'b1 || tip_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset: ss=%b tip=%b want 1/0", ss_o, tip_o); end
  endtask

  task automatic test_div2_mode0;
    configure(1'b0, 3'd0, 3'd0);
    checks++; if (baud_div_o !== 12'd2) begin errors++; $display("FAIL div2_value: got %0d want 2", baud_div_o); end
    run_xfer(0, 100);
    checks++; if (r_timeout) begin errors++; $display("FAIL div2_timeout: transfer did not end in 100 cycles"); end
    checks++; if (r_send0 !== 1'b1) begin errors++; $display("FAIL div2_send: got %b want 1", r_send0); end
    checks++; if (r_ss_low != 18) begin errors++; $display("FAIL div2_ss_low: got %0d want 18", r_ss_low); end
    checks++; if (r_tog != 16) begin errors++; $display("FAIL div2_toggles: got %0d want 16", r_tog); end
    checks++; if (r_ms != 8 || r_mr != 8 || r_ms0 != 8 || r_mr0 != 8) begin
      errors++; $display("FAIL div2_strobes: got %0d/%0d/%0d/%0d want 8/8/8/8", r_ms, r_mr, r_ms0, r_mr0); end
    checks++; if (r_rx != 1) begin errors++; $display("FAIL div2_rx: got %0d want 1", r_rx); end
    checks++; if (r_tip_end !== 1'b0 || r_sclk_end !== 1'b0) begin
      errors++; $display("FAIL div2_end: tip=%b sclk=%b want 0/0", r_tip_end, r_sclk_end); end
  endtask

  task automatic test_div12_cpol1;
    configure(1'b1, 3'd2, 3'd1);
    checks++; if (baud_div_o !== 12'd12) begin errors++; $display("FAIL div12_value: got %0d want 12", baud_div_o); end
    checks++; if (sclk_o !== 1'b1) begin errors++; $display("FAIL div12_idle_sclk: got %b want 1", sclk_o); end
    run_xfer(0, 200);
    checks++; if (r_timeout || r_ss_low != 98) begin errors++; $display("FAIL div12_ss_low: got %0d want 98 (timeout=%0d)", r_ss_low, r_timeout); end
    checks++; if (r_ms != 8 || r_mr0 != 8) begin errors++; $display("FAIL div12_strobes: ms=%0d mr0=%0d want 8/8", r_ms, r_mr0); end
    checks++; if (r_pair != 8) begin errors++; $display("FAIL div12_ms_before_mr: got %0d want 8", r_pair); end
    checks++; if (r_sclk_end !== 1'b1 || r_rx != 1) begin errors++; $display("FAIL div12_end: sclk=%b rx=%0d want 1/1", r_sclk_end, r_rx); end
  endtask

  task automatic test_div2048;
    configure(1'b0, 3'd7, 3'd7);
    checks++; if (baud_div_o !== 12'd2048) begin errors++; $display("FAIL div2048_value: got %0d want 2048", baud_div_o); end
    run_xfer(0, 17000);
    checks++; if (r_timeout || r_ss_low != 16386) begin errors++; $display("FAIL div2048_ss_low: got %0d want 16386 (timeout=%0d)", r_ss_low, r_timeout); end
    checks++; if (r_tog != 16 || r_rx != 1) begin errors++; $display("FAIL div2048_end: tog=%0d rx=%0d want 16/1", r_tog, r_rx); end
  endtask

  task automatic test_abort;
    configure(1'b0, 3'd1, 3'd0);
    run_xfer(1, 100);
    checks++; if (r_timeout || r_ss_low != 12) begin errors++; $display("FAIL abort_ss_low: got %0d want 12 (timeout=%0d)", r_ss_low, r_timeout); end
    checks++; if (r_ss_end !== 1'b1 || r_sclk_end !== 1'b0 || r_tip_end !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: ss=%b sclk=%b tip=%b want 1/0/0", r_ss_end, r_sclk_end, r_tip_end); end
    checks++; if (r_rx != 0) begin errors++; $display("FAIL abort_rx: got %0d want 0", r_rx); end
    spe_i = 1'b1;
    tick(2);
    run_xfer(0, 100);
    checks++; if (r_timeout || r_ss_low != 34 || r_tog != 16 || r_rx != 1) begin
      errors++; $display("FAIL abort_restart: ss_low=%0d tog=%0d rx=%0d want 34/16/1", r_ss_low, r_tog, r_rx); end
  endtask

  task automatic test_shadow;
    configure(1'b0, 3'd1, 3'd0);
    run_xfer(2, 100);
    checks++; if (r_timeout || r_ss_low != 34 || r_tog != 16) begin
      errors++; $display("FAIL shadow_xfer: ss_low=%0d tog=%0d want 34/16", r_ss_low, r_tog); end
    checks++; if (r_div_changed) begin errors++; $display("FAIL shadow_div: baud_div_o changed mid-transfer, want stable 4"); end
    checks++; if (r_send != 0) begin errors++; $display("FAIL shadow_start_ignored: send pulses=%0d want 0", r_send); end
    tick(2);
    checks++; if (baud_div_o !== 12'd8 || sclk_o !== 1'b1) begin
      errors++; $display("FAIL shadow_after: div=%0d sclk=%b want 8/1", baud_div_o, sclk_o); end
  endtask

  task automatic test_wait;
    configure(1'b0, 3'd1, 3'd0);
    run_xfer(3, 200);
    checks++; if (r_tog != 16 || r_rx != 1 || r_timeout) begin
      errors++; $display("FAIL wait_complete: tog=%0d rx=%0d want 16/1", r_tog, r_rx); end
    checks++; if (r_ms != 8 || r_mr != 8 || r_ms0 != 8 || r_mr0 != 8) begin
      errors++; $display("FAIL wait_strobes: got %0d/%0d/%0d/%0d want 8/8/8/8", r_ms, r_mr, r_ms0, r_mr0); end
`ifdef SPI_WAIT_FREEZE_EN
    checks++; if (r_ss_low != 44) begin errors++; $display("FAIL wait_ss_low: got %0d want 44", r_ss_low); end
    checks++; if (r_frz_bad != 0) begin errors++; $display("FAIL wait_frozen: %0d bad cycles want 0", r_frz_bad); end
`else
    checks++; if (r_ss_low != 34) begin errors++; $display("FAIL wait_ignored: ss_low=%0d want 34", r_ss_low); end
`endif
  endtask

  task automatic test_reset_mid;
    bit seen;
    configure(1'b0, 3'd0, 3'd0);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ss_o === 1'b0 && sclk_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach: no active high SCLK within 20 cycles"); end
    PRESET_n = 1'b0;
    #1;
    checks++; if (ss_o !== 1'b1 || sclk_o !== 1'b0 || tip_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: ss=%b sclk=%b tip=%b want 1/0/0", ss_o, sclk_o, tip_o); end
    checks++;
    if ({receive_data_o, mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o,
         miso_receive_sclk0_o} !== 5'b0 || baud_div_o !== 12'd2) begin
      errors++; $display("FAIL rstmid_pulses: pulses=%b div=%0d want 00000/2",
        {receive_data_o, mosi_send_sclk_o, miso_receive_sclk_o, mosi_send_sclk0_o,
         miso_receive_sclk0_o}, baud_div_o);
    end
    tick(2);
    #2 PRESET_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_div2_mode0();
    test_div12_cpol1();
    test_div2048();
    test_abort();
    test_shadow();
    test_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
